// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences IF/ID/EXE/MEM/WB and decodes all datapath
// enables and ALU32 controls from the registered state and the opcode.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       sign,
    output logic [2:0] ALUopcode,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic       RegDst,
    output logic       WrRegDSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t state_q, state_d;
    logic   halt_q, halt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // HALT is ID with halt_q set, so the debug state port keeps showing 001.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (!halt_q) begin
                    case (op)
                        OP_J:                     state_d = S_IF;
                        OP_HALT:                  halt_d  = 1'b1;
                        OP_BEQ, OP_BNE, OP_BLTZ:  state_d = S_EXE_BR;
                        OP_LW, OP_SW:             state_d = S_EXE_LS;
                        default:                  state_d = S_EXE_AL;
                    endcase
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (op == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    logic       is_r, is_i, taken;
    logic [2:0] alu_code;

    always_comb begin
        is_r = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_SLT);
        is_i = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_SLTIU);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: alu_code = 3'd1;
            OP_AND, OP_ANDI:                 alu_code = 3'd2;
            OP_OR, OP_ORI:                   alu_code = 3'd3;
            OP_SLTIU:                        alu_code = 3'd4;
            OP_SLT:                          alu_code = 3'd5;
            default:                         alu_code = 3'd0;
        endcase
        case (op)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = !zero;
            OP_BLTZ: taken = sign;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        ALUopcode = '0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        WrRegDSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        state     = reset ? '0 : state_q;
        if (!reset && !halt_q) begin
            // ALU controls stay driven from EXE through MEM/WB so the result holds.
            if (state_q != S_IF && state_q != S_ID) begin
                ALUopcode = alu_code;
                ALUSrcB   = is_i || (op == OP_LW) || (op == OP_SW);
                ExtSel    = !((op == OP_ANDI) || (op == OP_ORI));
            end
            case (state_q)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (op == OP_J) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    PCSrc = {1'b0, taken};
                end
                S_WB_AL: begin
                    RegWre = is_r || is_i;
                    RegDst = is_r;
                    PCWre  = 1'b1;
                end
                S_MEM: begin
                    mWR   = (op == OP_SW);
                    mRD   = (op == OP_LW);
                    PCWre = (op == OP_SW);
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    mRD       = 1'b1;
                    PCWre     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
